// File: rtl/input_loader.sv
// Streams one input vector into the banked I/O SRAMs.
// Element i lands in bank i mod NBANKS, word i / NBANKS.
module input_loader #(
  parameter int DATA_W = 16,
  parameter int NBANKS = 64,
  parameter int ADDR_W = 4,
  parameter int N_ELEM = 784
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [NBANKS-1:0] wr_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int EW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [BW-1:0] BANK_LAST = BW'(NBANKS - 1);
  localparam logic [EW-1:0] ELEM_LAST = EW'(N_ELEM - 1);
  localparam logic [NBANKS-1:0] ONE = NBANKS'(1);

  if (N_ELEM == 0 || N_ELEM > NBANKS * (2 ** ADDR_W)) begin : g_bad
    $error("input_loader: N_ELEM does not fit the banks");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH
  } state_t;

  state_t state;

  logic [BW-1:0]     bank_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic [EW-1:0]     elem_cnt;
  logic              accept;

  // Abort masks ready so a pixel offered alongside it is dropped.
  assign in_ready = (state == LOAD) && !abort;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bank_cnt <= '0;
      word_cnt <= '0;
      elem_cnt <= '0;
      wr_we    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
    end else begin
      wr_we <= '0;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            state    <= LOAD;
            bank_cnt <= '0;
            word_cnt <= '0;
            elem_cnt <= '0;
          end
        end
        LOAD: begin
          if (abort) begin
            state    <= IDLE;
            bank_cnt <= '0;
            word_cnt <= '0;
            elem_cnt <= '0;
          end else if (accept) begin
            wr_we   <= ONE << bank_cnt;
            wr_addr <= word_cnt;
            wr_data <= in_data;
            if (elem_cnt == ELEM_LAST) begin
              state    <= FLUSH;
              bank_cnt <= '0;
              word_cnt <= '0;
              elem_cnt <= '0;
            end else begin
              elem_cnt <= elem_cnt + 1'b1;
              if (bank_cnt == BANK_LAST) begin
                bank_cnt <= '0;
                word_cnt <= word_cnt + 1'b1;
              end else begin
                bank_cnt <= bank_cnt + 1'b1;
              end
            end
          end
        end
        FLUSH: begin
          state <= IDLE;
          done  <= !abort;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_loader.sv
// Bench for input_loader: vector table, then model-checked
// continuous, gapped, start/abort/reset scenarios.
module tb_input_loader;

  localparam int DW = 16;
  localparam int NB = 64;
  localparam int AW = 4;
  localparam int NE = 784;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_FLUSH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [NB-1:0] wr_we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;
  int mode    = M_IDLE;
  int k       = 0;
  int n_wr    = 0;
  int n_done  = 0;

  input_loader #(
    .DATA_W(DW), .NBANKS(NB), .ADDR_W(AW), .N_ELEM(NE)
  ) dut (
    .clk(clk), .rst(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_we(wr_we), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %h expected %h", nm, $time, got, exp);
    end
  endtask

  // Drive one cycle; model the expected bus from element index arithmetic.
  task automatic step(input bit v, input logic [DW-1:0] d,
                      input bit s, input bit a);
    bit acc;
    logic [NB-1:0] ewe;
    int eaddr;
    bit edone;
    in_valid = v; in_data = d; start = s; abort = a;
    #1;
    chk("in_ready", 64'(in_ready), 64'(mode == M_LOAD && !a));
    acc   = v && mode == M_LOAD && !a;
    ewe   = acc ? (NB'(1) << (k % NB)) : '0;
    eaddr = k / NB;
    edone = (mode == M_FLUSH) && !a;
    case (mode)
      M_IDLE: if (s && !a) begin mode = M_LOAD; k = 0; end
      M_LOAD: begin
        if (a) begin
          mode = M_IDLE; k = 0;
        end else if (acc) begin
          k++;
          if (k == NE) begin mode = M_FLUSH; k = 0; end
        end
      end
      default: mode = M_IDLE;
    endcase
    @(posedge clk); #1;
    chk("wr_we", 64'(wr_we), 64'(ewe));
    if (ewe != '0) begin
      chk("wr_addr", 64'(wr_addr), 64'(eaddr));
      chk("wr_data", 64'(wr_data), 64'(d));
    end
    chk("done", 64'(done), 64'(edone));
    chk("busy", 64'(busy), 64'(mode != M_IDLE));
    if (wr_we != '0) n_wr++;
    if (done) n_done++;
  endtask

  task automatic do_reset();
    start = 0; abort = 0; in_valid = 0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_we", 64'(wr_we), 64'd0);
    chk("rst_addr", 64'(wr_addr), 64'd0);
    chk("rst_data", 64'(wr_data), 64'd0);
    chk("rst_flags", {61'd0, busy, done, in_ready}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mode = M_IDLE; k = 0;
  endtask

  // Run the current load to completion with the given gap percentage.
  task automatic run_load(input int gap);
    int guard = 0;
    while (mode == M_LOAD && guard < 20000) begin
      step($urandom_range(99) >= gap, DW'($urandom), 0, 0);
      guard++;
    end
    n_tests++;
    if (mode == M_LOAD) begin
      n_fail++;
      $display("FAIL load_timeout still loading after %0d cycles", guard);
    end
    repeat (3) step(0, 0, 0, 0);
  endtask

  typedef struct {
    bit s, a, v;
    logic [DW-1:0] d;
    bit rdy;
    int bank;
    int addr;
    bit bsy;
    bit dn;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{0, 0, 1, 16'hAAAA, 0, -1, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 16'h0000, 0, -1, 0, 1, 0};
    tbl[2] = '{0, 0, 1, 16'h0011, 1,  0, 0, 1, 0};
    tbl[3] = '{0, 0, 0, 16'h0000, 1, -1, 0, 1, 0};
    tbl[4] = '{0, 0, 1, 16'h0022, 1,  1, 0, 1, 0};
    tbl[5] = '{0, 1, 1, 16'h0033, 0, -1, 0, 0, 0};
    tbl[6] = '{1, 1, 0, 16'h0000, 0, -1, 0, 0, 0};
    tbl[7] = '{1, 0, 0, 16'h0000, 0, -1, 0, 1, 0};
    tbl[8] = '{0, 0, 1, 16'h0044, 1,  0, 0, 1, 0};
    tbl[9] = '{0, 1, 0, 16'h0000, 0, -1, 0, 0, 0};

    do_reset();

    for (int i = 0; i < 10; i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d;
      start = tbl[i].s; abort = tbl[i].a;
      #1;
      chk("tbl_ready", 64'(in_ready), 64'(tbl[i].rdy));
      @(posedge clk); #1;
      chk("tbl_we", 64'(wr_we),
          tbl[i].bank < 0 ? 64'd0 : 64'(NB'(1) << tbl[i].bank));
      if (tbl[i].bank >= 0) begin
        chk("tbl_addr", 64'(wr_addr), 64'(tbl[i].addr));
        chk("tbl_data", 64'(wr_data), 64'(tbl[i].d));
      end
      chk("tbl_busy", 64'(busy), 64'(tbl[i].bsy));
      chk("tbl_done", 64'(done), 64'(tbl[i].dn));
    end
    mode = M_IDLE; k = 0;

    // Continuous stream, in_data = element index.
    n_wr = 0; n_done = 0;
    step(0, 0, 1, 0);
    for (int i = 0; i < NE; i++) step(1, DW'(i), 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    chk("cont_writes", 64'(n_wr), 64'(NE));
    chk("cont_dones", 64'(n_done), 64'd1);

    // Random ~50% gaps.
    n_wr = 0; n_done = 0;
    step(0, 0, 1, 0);
    run_load(50);
    chk("gap_writes", 64'(n_wr), 64'(NE));
    chk("gap_dones", 64'(n_done), 64'd1);

    // start re-pulsed at element 300 is ignored.
    n_wr = 0; n_done = 0;
    step(0, 0, 1, 0);
    for (int i = 0; i < NE; i++) step(1, DW'(i), i == 300, 0);
    repeat (3) step(0, 0, 0, 0);
    chk("restart_writes", 64'(n_wr), 64'(NE));
    chk("restart_dones", 64'(n_done), 64'd1);

    // Reset mid-load, then full reload.
    step(0, 0, 1, 0);
    for (int i = 0; i < 100; i++) step(1, DW'(i), 0, 0);
    do_reset();
    n_wr = 0; n_done = 0;
    step(0, 0, 1, 0);
    run_load(30);
    chk("rst_writes", 64'(n_wr), 64'(NE));
    chk("rst_dones", 64'(n_done), 64'd1);

    // Abort with a pixel offered at element 500.
    n_wr = 0; n_done = 0;
    step(0, 0, 1, 0);
    for (int i = 0; i < 500; i++) step(1, DW'(i), 0, 0);
    step(1, 16'hBEEF, 0, 1);
    repeat (3) step(1, 16'hDEAD, 0, 0);
    chk("abort_writes", 64'(n_wr), 64'd500);
    chk("abort_dones", 64'(n_done), 64'd0);
    n_wr = 0; n_done = 0;
    step(0, 0, 1, 0);
    run_load(40);
    chk("abort_rl_wr", 64'(n_wr), 64'(NE));
    chk("abort_rl_dn", 64'(n_done), 64'd1);

    // Valid held in IDLE without start.
    n_wr = 0;
    for (int i = 0; i < 10; i++) step(1, DW'(i + 7), 0, 0);
    chk("idle_writes", 64'(n_wr), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
